// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stage registers: occupancy state,
// occupancy width and the packed bundle widths of the stage boundaries.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  localparam int OCC_W   = 2;
  localparam int ID_EX_W = 229;

  function automatic logic [OCC_W-1:0] occ_of(input stage_state_t s);
    case (s)
      EMPTY:   occ_of = 2'd0;
      ONE:     occ_of = 2'd1;
      FULL:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One bundle-wide storage slot: async reset to zero, synchronous clear that
// takes priority over load.
module pipe_slot #(
  parameter int WIDTH = 229
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      q_o <= '0;
    end else if (clear_i) begin
      q_o <= '0;
    end else if (load_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline stage register with optional two-entry skid
// buffer and synchronous flush that leaves a bubble.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH          = 229,
  parameter int SKID           = 1,
  parameter int CLEAR_ON_FLUSH = 1
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [OCC_W-1:0] occupancy_o
);

  stage_state_t     st_q, st_d;
  logic             acc, pop;
  logic             main_load, main_from_skid, skid_load, clr;
  logic [WIDTH-1:0] main_d, skid_q;

  assign acc    = in_valid_i & in_ready_o;
  assign pop    = out_valid_o & out_ready_i;
  assign clr    = flush_i & (CLEAR_ON_FLUSH != 0);
  assign main_d = main_from_skid ? skid_q : in_data_i;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= EMPTY;
    end else begin
      st_q <= st_d;
    end
  end

  // With SKID=0 ready implies pop whenever ONE, so the ONE->FULL arc never fires.
  always_comb begin
    st_d           = st_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush_i) begin
      st_d = EMPTY;
    end else begin
      case (st_q)
        EMPTY: begin
          if (acc) begin
            st_d      = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (acc && !pop) begin
            st_d      = FULL;
            skid_load = 1'b1;
          end else if (acc && pop) begin
            main_load = 1'b1;
          end else if (pop) begin
            st_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            st_d           = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: st_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid_o = (st_q != EMPTY);
    occupancy_o = occ_of(st_q);
  end

  pipe_slot #(.WIDTH(WIDTH)) u_main (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .load_i (main_load),
    .clear_i(clr),
    .d_i    (main_d),
    .q_o    (out_data_o)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic rdy_q;

      // Registered ready keeps the downstream stall off the upstream timing path.
      always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
          rdy_q <= 1'b1;
        end else begin
          rdy_q <= (st_d != FULL);
        end
      end
      assign in_ready_o = rdy_q;

      pipe_slot #(.WIDTH(WIDTH)) u_skid (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .load_i (skid_load),
        .clear_i(clr),
        .d_i    (in_data_i),
        .q_o    (skid_q)
      );
    end else begin : g_noskid
      logic unused_skid_load;
      assign unused_skid_load = skid_load;
      assign in_ready_o       = !out_valid_o | out_ready_i;
      assign skid_q           = '0;
    end
  endgenerate

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic pipeline stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces fixed-width, always-loading stage registers with a valid/ready handshake, an optional two-entry skid buffer for stalls, and a synchronous flush that inserts a bubble. Each stage boundary instantiates it with its own packed bundle width.

## Interface
- WIDTH, 229, width of the packed stage bundle in bits (≥1)
- SKID, 1, 1 = two-entry skid buffer with registered in_ready_o; 0 = single entry with combinational ready
- CLEAR_ON_FLUSH, 1, 1 = flush and reset zero the stored data; 0 = only valid bits cleared

- clk_i  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous flush; drops all held entries and the same-cycle input
- in_valid_i  in  1  upstream bundle valid
- in_ready_o  out  1  stage can accept; transfer when in_valid_i & in_ready_o
- in_data_i  in  WIDTH  upstream bundle
- out_valid_o  out  1  out_data_o holds a valid bundle
- out_ready_i  in  1  downstream accepts; pop when out_valid_o & out_ready_i (low = stall)
- out_data_o  out  WIDTH  bundle to next stage, driven from the main register
- occupancy_o  out  2  entries held: 0, 1, 2 (2 only when SKID=1)

## Operation
- Storage: main register (drives out_data_o) plus skid register (SKID=1 only).
- States: EMPTY, ONE, FULL (FULL unreachable when SKID=0).
- acc = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
- EMPTY: acc → ONE, main ← in_data_i.
- ONE: acc & !pop → FULL, skid ← in_data_i; pop & !acc → EMPTY; acc & pop → ONE, main ← in_data_i; neither → hold.
- FULL: in_ready_o = 0; pop → ONE, main ← skid; no pop → hold both.
- SKID=1: in_ready_o registered, = (next state != FULL).
- SKID=0: in_ready_o = !out_valid_o | out_ready_i (combinational); states EMPTY/ONE only.
- out_valid_o = (state != EMPTY); occupancy_o = 0/1/2 for EMPTY/ONE/FULL.
- Flush: next state EMPTY regardless of acc/pop; same-cycle input discarded; if CLEAR_ON_FLUSH, main and skid ← 0, else data held.
- in_data_i ignored unless acc; out_data_o stable while out_valid_o & !out_ready_i.
- Reset precedence: rst_n > flush_i > handshake.

## Timing
- Reset values: state EMPTY, out_valid_o 0, occupancy_o 0, out_data_o 0, skid 0, in_ready_o 1.
- Latency: accept in cycle N → out_valid_o with that data in cycle N+1.
- Throughput: one bundle per cycle with out_ready_i held high, both modes.
- SKID=1: out_ready_i deasserted for one cycle costs no upstream data; upstream sees in_ready_o = 0 one cycle after FULL is entered, never combinationally.
- SKID=0: out_ready_i → in_ready_o is a combinational path; no other comb paths input→output.
- Flush at edge N: cycle N+1 out_valid_o = 0, occupancy_o = 0, in_ready_o = 1.
- rst_n asserted mid-transfer: all outputs go to reset values immediately (asynchronous); held entries lost; first accept possible on first edge after release.
- Order preserved: bundles leave in acceptance order; no duplication, no loss except by flush/reset.

## Structure
- Shared package pipe_pkg: stage_state_t enum (EMPTY, ONE, FULL), OCC_W = 2 constant, per-boundary bundle-width constants (e.g. ID_EX_W = 229).
- Field packing/unpacking of bundles stays at the instantiating stage, not in this block.
- One sub-module: pipe_slot — WIDTH-bit register with load, clear (synchronous) and async reset; instantiated as main and (generate on SKID) skid.

## Test plan
- Streaming: SKID=1, WIDTH=8, out_ready_i=1, send 0x01..0x10 back-to-back → same 16 values out in order, one per cycle, one-cycle latency, occupancy_o ≤ 1.
- Stall/skid: send 0xA1,0xA2,0xA3 continuously, drop out_ready_i for 2 cycles after 0xA1 appears → occupancy_o reaches 2, in_ready_o low one cycle later, output 0xA1,0xA2,0xA3 with no loss.
- Flush in FULL with in_valid_i=1 (data 0x55) → next cycle out_valid_o=0, occupancy_o=0, out_data_o=0x00, 0x55 never emitted.
- SKID=0: out_ready_i=0 while ONE → in_ready_o=0 same cycle; out_ready_i=1 with in_valid_i=1 → replace-in-place, throughput one per cycle.
- Async reset asserted mid-cycle while FULL → out_valid_o=0, in_ready_o=1, out_data_o=0 before next edge; accept resumes on first edge after release.
- CLEAR_ON_FLUSH=0: flush with main=0x3C → out_valid_o=0, out_data_o remains 0x3C.
